// File: rtl/ad9945_pkg.sv
// ad9945_pkg
// Shared constants and types for the AD9945 serial configuration receiver:
// register addresses, shadow register widths, frame field widths and the
// receive FSM state encoding.
package ad9945_pkg;

  localparam logic [2:0] ADDR_OPER  = 3'd0;
  localparam logic [2:0] ADDR_CTRL  = 3'd1;
  localparam logic [2:0] ADDR_CLAMP = 3'd2;
  localparam logic [2:0] ADDR_VGA   = 3'd3;

  localparam int OPER_W  = 7;
  localparam int CTRL_W  = 7;
  localparam int CLAMP_W = 8;
  localparam int VGA_W   = 10;

  localparam int ADDR_BITS = 3;
  localparam int DATA_BITS = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } rx_state_t;

endpackage

// File: rtl/ad9945_sync_edge.sv
// ad9945_sync_edge
// Multi-flop synchronizer for one asynchronous pad input, with single-cycle
// rise/fall pulses derived from the synchronized level.
// Ports:
//   clk, rst : system clock, asynchronous active-high reset
//   d        : asynchronous pad input
//   q        : synchronized level
//   rise     : one-cycle pulse on a synchronized 0->1 transition
//   fall     : one-cycle pulse on a synchronized 1->0 transition
module ad9945_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;

  // Synchronizer chain plus one extra flop holding the previous level for
  // edge detection. Everything clears to 0 so a line already high at reset
  // release only looks like a rise, which an idle receiver ignores.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  end

  assign q    = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;

endmodule

// File: rtl/ad9945_serial_rx.sv
// ad9945_serial_rx
// Receiving end of the AD9945 3-wire serial port (SL/SCK/SDATA). Frames are
// a 3-bit address followed by 12-bit data words, LSB first, sampled on SCK
// rise while SL is low. Completed words update a shadow register set.
// Configuration macro: AD9945_RX_AUTOINC_EN
//   defined   : multi-word frames, address auto-increments after each word
//   undefined : one word per frame, later SCK edges ignored until SL rises
// Ports:
//   sys_clk, rst            : system clock, asynchronous active-high reset
//   SCK, SDATA, SL          : asynchronous serial pads (SL active low)
//   Oper, Ctrl, Clamp,
//   VGA_Gain                : shadow registers 0..3
//   wr_strobe/addr/data     : one-cycle pulse and payload per completed word
//   frame_err               : one-cycle pulse when SL rises mid-word
module ad9945_serial_rx
  import ad9945_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [7:0]  CLAMP_RST   = 8'h80
) (
  input  logic               sys_clk,
  input  logic               rst,
  input  logic               SCK,
  input  logic               SDATA,
  input  logic               SL,
  output logic [OPER_W-1:0]  Oper,
  output logic [CTRL_W-1:0]  Ctrl,
  output logic [CLAMP_W-1:0] Clamp,
  output logic [VGA_W-1:0]   VGA_Gain,
  output logic               wr_strobe,
  output logic [2:0]         wr_addr,
  output logic [11:0]        wr_data,
  output logic               frame_err
);

  localparam logic [3:0] ADDR_LAST = 4'(ADDR_BITS - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);

  logic sck_rise, sck_unused_lvl, sck_unused_fall;
  logic sd_lvl, sd_unused_rise, sd_unused_fall;
  logic sl_lvl, sl_rise, sl_fall;

  ad9945_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(sys_clk), .rst(rst), .d(SCK),
    .q(sck_unused_lvl), .rise(sck_rise), .fall(sck_unused_fall)
  );

  ad9945_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdata (
    .clk(sys_clk), .rst(rst), .d(SDATA),
    .q(sd_lvl), .rise(sd_unused_rise), .fall(sd_unused_fall)
  );

  ad9945_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sl (
    .clk(sys_clk), .rst(rst), .d(SL),
    .q(sl_lvl), .rise(sl_rise), .fall(sl_fall)
  );

  rx_state_t   state;
  logic [3:0]  cnt;
  logic [2:0]  addr;
  logic [11:0] word;
  logic        commit_pend;
  logic [2:0]  commit_addr;
  logic [11:0] commit_word;
  logic        err_pend;

  // Frame FSM. SL rise is checked before SCK so a coincident bit is dropped.
  // A finished word is handed to the output stage one cycle later through
  // commit_*, which keeps every output registered.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      addr        <= 3'd0;
      word        <= 12'd0;
      commit_pend <= 1'b0;
      commit_addr <= 3'd0;
      commit_word <= 12'd0;
      err_pend    <= 1'b0;
    end else begin
      commit_pend <= 1'b0;
      err_pend    <= 1'b0;
      case (state)
        IDLE: begin
          if (sl_fall) begin
            state <= ADDR;
            cnt   <= 4'd0;
          end
        end
        ADDR: begin
          if (sl_rise) begin
            state    <= IDLE;
            err_pend <= (cnt != 4'd0);
            cnt      <= 4'd0;
          end else if (sck_rise && !sl_lvl) begin
            addr[cnt[1:0]] <= sd_lvl;
            if (cnt == ADDR_LAST) begin
              state <= DATA;
              cnt   <= 4'd0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (sl_rise) begin
            state    <= IDLE;
            err_pend <= (cnt != 4'd0);
            cnt      <= 4'd0;
          end else if (sck_rise && !sl_lvl) begin
            word[cnt] <= sd_lvl;
            if (cnt == DATA_LAST) begin
              commit_pend <= 1'b1;
              commit_addr <= addr;
              commit_word <= {sd_lvl, word[10:0]};
              cnt         <= 4'd0;
`ifdef AD9945_RX_AUTOINC_EN
              addr        <= addr + 3'd1;
`else
              state       <= DONE;
`endif
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        DONE: begin
          if (sl_rise) begin
            state <= IDLE;
            cnt   <= 4'd0;
          end
        end
      endcase
    end
  end

  // Output stage: strobe, payload and shadow register update land together.
  // Addresses 4-7 still strobe but touch no register.
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      Oper      <= '0;
      Ctrl      <= '0;
      Clamp     <= CLAMP_RST;
      VGA_Gain  <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= 3'd0;
      wr_data   <= 12'd0;
      frame_err <= 1'b0;
    end else begin
      wr_strobe <= commit_pend;
      frame_err <= err_pend;
      if (commit_pend) begin
        wr_addr <= commit_addr;
        wr_data <= commit_word;
        case (commit_addr)
          ADDR_OPER:  Oper     <= commit_word[OPER_W-1:0];
          ADDR_CTRL:  Ctrl     <= commit_word[CTRL_W-1:0];
          ADDR_CLAMP: Clamp    <= commit_word[CLAMP_W-1:0];
          ADDR_VGA:   VGA_Gain <= commit_word[VGA_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad9945_serial_rx.sv
// tb_ad9945_serial_rx
// Directed self-checking bench for ad9945_serial_rx. Drives serial frames
// through the pads at slow SCK and checks shadow registers, write strobes
// and frame errors. Expectations follow AD9945_RX_AUTOINC_EN when defined.
module tb_ad9945_serial_rx;

  logic        sys_clk;
  logic        rst;
  logic        SCK;
  logic        SDATA;
  logic        SL;
  logic [6:0]  Oper;
  logic [6:0]  Ctrl;
  logic [7:0]  Clamp;
  logic [9:0]  VGA_Gain;
  logic        wr_strobe;
  logic [2:0]  wr_addr;
  logic [11:0] wr_data;
  logic        frame_err;

  int tests_run    = 0;
  int tests_failed = 0;

  int          strobe_cnt = 0;
  int          err_cnt    = 0;
  logic [2:0]  log_addr [16];
  logic [11:0] log_data [16];

  ad9945_serial_rx #(.SYNC_STAGES(2), .CLAMP_RST(8'h80)) dut (
    .sys_clk(sys_clk), .rst(rst), .SCK(SCK), .SDATA(SDATA), .SL(SL),
    .Oper(Oper), .Ctrl(Ctrl), .Clamp(Clamp), .VGA_Gain(VGA_Gain),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .frame_err(frame_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Log every strobe payload and count cycles with frame_err high.
  always @(negedge sys_clk) begin
    if (wr_strobe) begin
      log_addr[strobe_cnt[3:0]] = wr_addr;
      log_data[strobe_cnt[3:0]] = wr_data;
      strobe_cnt = strobe_cnt + 1;
    end
    if (frame_err) err_cnt = err_cnt + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    tests_run = tests_run + 1;
    if (got !== exp) begin
      tests_failed = tests_failed + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic sendBits(input logic [11:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      SDATA = v[i];
      waitCycles(6);
      SCK = 1'b1;
      waitCycles(6);
      SCK = 1'b0;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] a, input logic [11:0] w0,
                               input logic [11:0] w1, input logic [11:0] w2,
                               input int nwords);
    SL = 1'b0;
    waitCycles(8);
    sendBits({9'd0, a}, 3);
    if (nwords > 0) sendBits(w0, 12);
    if (nwords > 1) sendBits(w1, 12);
    if (nwords > 2) sendBits(w2, 12);
    waitCycles(6);
    SL = 1'b1;
    waitCycles(12);
  endtask

  int s0, e0;

  initial begin
    rst = 1'b1; SCK = 1'b0; SDATA = 1'b0; SL = 1'b1;
    waitCycles(4);
    rst = 1'b0;
    waitCycles(20);

    // Reset values, no activity
    checkOutput("rst_oper", 32'(Oper), 32'h0);
    checkOutput("rst_ctrl", 32'(Ctrl), 32'h0);
    checkOutput("rst_clamp", 32'(Clamp), 32'h80);
    checkOutput("rst_vga", 32'(VGA_Gain), 32'h0);
    checkOutput("rst_strobes", 32'(strobe_cnt), 32'd0);
    checkOutput("rst_errs", 32'(err_cnt), 32'd0);

    // Single word to VGA_Gain
    s0 = strobe_cnt; e0 = err_cnt;
    applyStimulus(3'd3, 12'h2A5, 12'h0, 12'h0, 1);
    checkOutput("vga_strobes", 32'(strobe_cnt - s0), 32'd1);
    checkOutput("vga_wr_addr", 32'(log_addr[4'(s0)]), 32'd3);
    checkOutput("vga_wr_data", 32'(log_data[4'(s0)]), 32'h2A5);
    checkOutput("vga_value", 32'(VGA_Gain), 32'h2A5);
    checkOutput("vga_oper", 32'(Oper), 32'h0);
    checkOutput("vga_ctrl", 32'(Ctrl), 32'h0);
    checkOutput("vga_clamp", 32'(Clamp), 32'h80);
    checkOutput("vga_errs", 32'(err_cnt - e0), 32'd0);

    // SL raised after 5 data bits to Clamp
    s0 = strobe_cnt; e0 = err_cnt;
    SL = 1'b0;
    waitCycles(8);
    sendBits(12'h002, 3);
    sendBits(12'h0FF, 5);
    waitCycles(6);
    SL = 1'b1;
    waitCycles(12);
    checkOutput("err_pulses", 32'(err_cnt - e0), 32'd1);
    checkOutput("err_strobes", 32'(strobe_cnt - s0), 32'd0);
    checkOutput("err_clamp", 32'(Clamp), 32'h80);

    // Empty frame (SL low then high, no bits) ends cleanly
    e0 = err_cnt;
    SL = 1'b0;
    waitCycles(10);
    SL = 1'b1;
    waitCycles(12);
    checkOutput("empty_errs", 32'(err_cnt - e0), 32'd0);

    // Three-word frame from address 0
    s0 = strobe_cnt; e0 = err_cnt;
    applyStimulus(3'd0, 12'h015, 12'h03C, 12'h0F0, 3);
`ifdef AD9945_RX_AUTOINC_EN
    checkOutput("ai_strobes", 32'(strobe_cnt - s0), 32'd3);
    checkOutput("ai_addr0", 32'(log_addr[4'(s0)]), 32'd0);
    checkOutput("ai_addr1", 32'(log_addr[4'(s0 + 1)]), 32'd1);
    checkOutput("ai_addr2", 32'(log_addr[4'(s0 + 2)]), 32'd2);
    checkOutput("ai_data2", 32'(log_data[4'(s0 + 2)]), 32'h0F0);
    checkOutput("ai_oper", 32'(Oper), 32'h15);
    checkOutput("ai_ctrl", 32'(Ctrl), 32'h3C);
    checkOutput("ai_clamp", 32'(Clamp), 32'hF0);
`else
    checkOutput("ai_strobes", 32'(strobe_cnt - s0), 32'd1);
    checkOutput("ai_addr0", 32'(log_addr[4'(s0)]), 32'd0);
    checkOutput("ai_data0", 32'(log_data[4'(s0)]), 32'h015);
    checkOutput("ai_oper", 32'(Oper), 32'h15);
    checkOutput("ai_ctrl", 32'(Ctrl), 32'h0);
    checkOutput("ai_clamp", 32'(Clamp), 32'h80);
`endif
    checkOutput("ai_errs", 32'(err_cnt - e0), 32'd0);

    // Frame starting at address 7, two words
    s0 = strobe_cnt; e0 = err_cnt;
    applyStimulus(3'd7, 12'hA5A, 12'h9C3, 12'h0, 2);
    checkOutput("wrap_addr0", 32'(log_addr[4'(s0)]), 32'd7);
    checkOutput("wrap_data0", 32'(log_data[4'(s0)]), 32'hA5A);
    checkOutput("wrap_vga", 32'(VGA_Gain), 32'h2A5);
`ifdef AD9945_RX_AUTOINC_EN
    checkOutput("wrap_strobes", 32'(strobe_cnt - s0), 32'd2);
    checkOutput("wrap_addr1", 32'(log_addr[4'(s0 + 1)]), 32'd0);
    checkOutput("wrap_oper", 32'(Oper), 32'h43);
`else
    checkOutput("wrap_strobes", 32'(strobe_cnt - s0), 32'd1);
    checkOutput("wrap_oper", 32'(Oper), 32'h15);
`endif
    checkOutput("wrap_errs", 32'(err_cnt - e0), 32'd0);

    // Reset mid-frame after 8 data bits, then a clean frame to Ctrl
    e0 = err_cnt;
    SL = 1'b0;
    waitCycles(8);
    sendBits(12'h001, 3);
    sendBits(12'hFFF, 8);
    rst = 1'b1;
    SL  = 1'b1;
    waitCycles(3);
    rst = 1'b0;
    waitCycles(10);
    checkOutput("mrst_oper", 32'(Oper), 32'h0);
    checkOutput("mrst_clamp", 32'(Clamp), 32'h80);
    checkOutput("mrst_vga", 32'(VGA_Gain), 32'h0);
    s0 = strobe_cnt;
    applyStimulus(3'd1, 12'h07F, 12'h0, 12'h0, 1);
    checkOutput("mrst_errs", 32'(err_cnt - e0), 32'd0);
    checkOutput("mrst_strobes", 32'(strobe_cnt - s0), 32'd1);
    checkOutput("mrst_wr_addr", 32'(log_addr[4'(s0)]), 32'd1);
    checkOutput("mrst_wr_data", 32'(log_data[4'(s0)]), 32'h07F);
    checkOutput("mrst_ctrl", 32'(Ctrl), 32'h7F);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ad9945_serial_rx.md
# ad9945_serial_rx

Receiving end of the AD9945 3-wire serial configuration port (SL/SCK/SDATA), running on `sys_clk`. It oversamples the serial lines, decodes address/data frames and holds a shadow copy of the Oper, Ctrl, Clamp and VGA_Gain registers. It is used as the AFE-side register model in the CCD testbenches and as an on-chip loopback checker against the configuration master.

## Interface
Parameters:
- `SYNC_STAGES`, 2: synchronizer depth on SCK/SDATA/SL (min 2).
- `CLAMP_RST`, 8'h80: Clamp reset value.

Ports:
- `sys_clk` in 1: only clock; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `SCK` in 1: serial clock, asynchronous to `sys_clk`; data is sampled on the SCK rising edge.
- `SDATA` in 1: serial data, LSB first.
- `SL` in 1: active-low frame (load) strobe.
- `Oper` out 7: shadow of register 0.
- `Ctrl` out 7: shadow of register 1.
- `Clamp` out 8: shadow of register 2.
- `VGA_Gain` out 10: shadow of register 3.
- `wr_strobe` out 1: one-cycle pulse per completed 12-bit data word.
- `wr_addr` out 3: address of the completed word; valid with `wr_strobe`, held otherwise.
- `wr_data` out 12: the completed word; valid with `wr_strobe`, held otherwise.
- `frame_err` out 1: one-cycle pulse when SL rises mid-word.

## Operation
- Each input passes through `SYNC_STAGES` flops. Edges are detected on the synchronized signals only.
- States:
  - IDLE: waiting for a frame.
  - ADDR: collecting the address; 2-bit counter.
  - DATA: collecting data; 4-bit counter.
- Transitions:
  - IDLE→ADDR on synchronized SL falling edge; counters clear.
  - ADDR: each SCK rise shifts SDATA into `addr[cnt]`. After the 3rd bit → DATA with `cnt=0`.
  - DATA: each SCK rise shifts SDATA into `word[cnt]`. On the 12th bit:
    - `wr_strobe=1`, `wr_addr=addr`, `wr_data=word` on the next cycle.
    - Target register loads `word[W-1:0]`, where W is the register width; the upper bits are discarded.
    - `addr` increments modulo 8 (7 wraps to 0) and `cnt` clears.
  - SL rising in any non-IDLE state → IDLE. If `cnt≠0`, or the state is ADDR with at least one bit received, `frame_err` pulses and partial bits are discarded; no register changes.
  - SL rising in ADDR with 0 bits, or in DATA with `cnt=0`, is a clean end of frame.
- Addresses 4–7: `wr_strobe` still fires; no shadow register changes.
- An SCK rise while SL is high is ignored.
- If SCK rise and SL rise are detected in the same cycle, SL wins and the bit is dropped.
- Reset values: `Oper=0`, `Ctrl=0`, `Clamp=CLAMP_RST`, `VGA_Gain=0`, `wr_strobe=0`, `wr_addr=0`, `wr_data=0`, `frame_err=0`, state IDLE.
- Reset asserted mid-frame aborts the frame without a `frame_err` pulse. After release, the block waits for a fresh SL falling edge.

## Timing
- SCK high and low times must each be ≥ `SYNC_STAGES+2` `sys_clk` periods. SDATA must be stable from 1 SCK half-period before the rise until 1 half-period after it.
- SL must be low ≥ `SYNC_STAGES+2` cycles before the first SCK rise.
- Pad SCK rise → bit captured: `SYNC_STAGES+1` cycles.
- 12th-bit pad edge → `wr_strobe` and register update: `SYNC_STAGES+2` cycles. The register value and `wr_strobe` are visible in the same cycle.
- Pad SL rise → `frame_err`: `SYNC_STAGES+2` cycles.
- All outputs are registered.

## Configuration
- `AD9945_RX_AUTOINC_EN` defined: multi-word frames as described above; the address auto-increments after each 12-bit word.
- Not defined: after the first word the FSM enters a DONE state and ignores further SCK edges until SL rises. SL rising in DONE is clean, with no `frame_err`. Only one register is written per frame.

## Structure
- Package `ad9945_pkg`:
  - Register address localparams `ADDR_OPER=0`, `ADDR_CTRL=1`, `ADDR_CLAMP=2`, `ADDR_VGA=3`.
  - Width constants 7/7/8/10.
  - FSM state enum (IDLE, ADDR, DATA, DONE).
  - Frame constants `ADDR_BITS=3`, `DATA_BITS=12`.
- Sub-module `ad9945_sync_edge`: N-flop synchronizer with rise/fall pulse outputs; instantiated three times.

## Test plan
- Reset release, then no activity → `Oper=0`, `Ctrl=0`, `Clamp=8'h80`, `VGA_Gain=0`; no strobes.
- Frame addr=3, data=12'h2A5 → one `wr_strobe`, `wr_addr=3`, `wr_data=12'h2A5`, `VGA_Gain=10'h2A5`; other registers unchanged.
- Autoinc frame addr=0 with words 12'h015, 12'h03C, 12'h0F0 → three strobes with `wr_addr` 0/1/2; `Oper=7'h15`, `Ctrl=7'h3C`, `Clamp=8'hF0`. With the macro off → only `Oper` updated.
- Frame addr=2 with SL raised after 5 data bits → `frame_err` pulse, no `wr_strobe`, `Clamp` stays 8'h80.
- Autoinc frame starting at addr=7 with two words → `wr_addr` 7 then 0; `Oper` takes the second word's low 7 bits.
- `rst` asserted after 8 data bits, released, then a clean frame addr=1 data=12'h07F → no `frame_err`; `Ctrl=7'h7F`.
